// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: stall arbitration,
// exception/ERET redirect, post-flush blanking, stall/flush stats, watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic        wdog_o
);

  localparam logic [31:0] LIM = 32'(WDOG_LIMIT);

  typedef enum logic {
    RUN,
    BLANK
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] run_cnt;
  logic        wdog;
  logic [31:0] vec;

  always_comb begin
    vec = EXC_VECTOR;
    case (excepttype_i)
      32'h0000_0001: vec = INT_VECTOR;
      32'h0000_000e: vec = cp0_epc_i;
      default:       vec = EXC_VECTOR;
    endcase
  end

  always_comb begin
    stall     = 6'b000000;
    flush     = 1'b0;
    new_pc    = 32'h0;
    state_nxt = state;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (|excepttype_i) begin
            flush     = 1'b1;
            new_pc    = vec;
            state_nxt = BLANK;
          end else begin
            priority case (1'b1)
              stallreq_from_mem: stall = 6'b011111;
              stallreq_from_ex:  stall = 6'b001111;
              stallreq_from_id:  stall = 6'b000111;
              stallreq_from_if:  stall = 6'b000011;
              default:           stall = 6'b000000;
            endcase
          end
        end
        // requests seen here come from squashed bubbles
        BLANK: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
      run_cnt   <= 32'h0;
      wdog      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (|stall) stall_cnt <= stall_cnt + 32'h1;
      if (flush) flush_cnt <= flush_cnt + 32'h1;
      if (flush || ~|stall) begin
        run_cnt <= 32'h0;
      end else begin
        if (run_cnt < LIM) run_cnt <= run_cnt + 32'h1;
        if (run_cnt + 32'h1 >= LIM) wdog <= 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
  assign wdog_o      = wdog;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_pipe_ctrl;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_if, r_id, r_ex, r_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, stall_cnt_o, flush_cnt_o;
  logic        wdog_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0040),
    .INT_VECTOR(32'h0000_0020),
    .WDOG_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_from_if(r_if),
    .stallreq_from_id(r_id),
    .stallreq_from_ex(r_ex),
    .stallreq_from_mem(r_mem),
    .excepttype_i(exc),
    .cp0_epc_i(epc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o),
    .wdog_o(wdog_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // model state: was the previous cycle a flush, counters, run length
  bit          m_blank;
  logic [31:0] m_sc, m_fc;
  int          m_run;
  bit          m_wd;

  function automatic bit e_flush();
    return !rst && !m_blank && (exc != 0);
  endfunction

  function automatic logic [5:0] e_stall();
    int n;
    if (rst || m_blank || exc != 0) return 6'd0;
    n = r_mem ? 5 : r_ex ? 4 : r_id ? 3 : r_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  function automatic logic [31:0] e_npc();
    if (!e_flush()) return 32'h0;
    if (exc == 32'h1) return 32'h20;
    if (exc == 32'he) return epc;
    return 32'h40;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_blank = 0;
      m_sc    = 0;
      m_fc    = 0;
      m_run   = 0;
      m_wd    = 0;
    end else begin
      bit         f;
      logic [5:0] s;
      f = e_flush();
      s = e_stall();
      if (s != 0) m_sc = m_sc + 1;
      if (f) m_fc = m_fc + 1;
      if (s != 0) begin
        if (m_run < LIM) m_run++;
        if (m_run >= LIM) m_wd = 1;
      end else begin
        m_run = 0;
      end
      m_blank = f;
    end
  end

  always @(negedge clk) begin
    chk("m_stall", 32'(stall), 32'(e_stall()));
    chk("m_flush", 32'(flush), 32'(e_flush()));
    chk("m_new_pc", new_pc, e_npc());
    chk("m_stall_cnt", stall_cnt_o, rst ? 32'h0 : m_sc);
    chk("m_flush_cnt", flush_cnt_o, rst ? 32'h0 : m_fc);
    chk("m_wdog", 32'(wdog_o), rst ? 32'h0 : 32'(m_wd));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic reqs(input logic a, b, c, d);
    r_if = a; r_id = b; r_ex = c; r_mem = d;
  endtask

  initial begin
    rst = 1'b1;
    reqs(0, 0, 0, 0);
    exc = 32'h0;
    epc = 32'hABCD_0010;
    step();
    step();
    // reset holds outputs low even with everything asserted
    reqs(1, 1, 1, 1);
    exc = 32'he;
    at_neg();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    step();
    rst = 1'b0;
    at_neg();
    chk("rel_flush", 32'(flush), 32'h1);
    chk("rel_new_pc", new_pc, 32'hABCD_0010);
    chk("rel_stall", 32'(stall), 32'h0);
    step();
    at_neg();
    chk("blank_flush", 32'(flush), 32'h0);
    chk("blank_stall", 32'(stall), 32'h0);
    step();
    reqs(0, 0, 0, 0);
    exc = 32'h0;

    // stall priority
    step(); reqs(1, 0, 0, 0); at_neg();
    chk("pri_if", 32'(stall), 32'h03);
    step(); reqs(0, 1, 0, 0); at_neg();
    chk("pri_id", 32'(stall), 32'h07);
    step(); reqs(0, 0, 1, 0); at_neg();
    chk("pri_ex", 32'(stall), 32'h0f);
    step(); reqs(0, 0, 0, 1); at_neg();
    chk("pri_mem", 32'(stall), 32'h1f);
    step(); reqs(1, 1, 1, 1); at_neg();
    chk("pri_all", 32'(stall), 32'h1f);
    step(); reqs(0, 0, 0, 0); at_neg();
    chk("stall_cnt5", stall_cnt_o, 32'd5);

    // exception vectors
    step(); exc = 32'h1; at_neg();
    chk("vec_int", new_pc, 32'h20);
    chk("vec_int_flush", 32'(flush), 32'h1);
    step(); exc = 32'h0; at_neg();
    chk("vec_int_one", 32'(flush), 32'h0);
    step(); exc = 32'hc; at_neg();
    chk("vec_ov", new_pc, 32'h40);
    step(); exc = 32'h0;
    step(); exc = 32'he; epc = 32'h0000_1234; at_neg();
    chk("vec_eret", new_pc, 32'h1234);
    step(); exc = 32'h0;
    step(); at_neg();
    chk("flush_cnt4", flush_cnt_o, 32'd4);

    // exception with stall, then blanking
    step(); r_mem = 1'b1; exc = 32'h8; at_neg();
    chk("sim_flush", 32'(flush), 32'h1);
    chk("sim_stall", 32'(stall), 32'h0);
    chk("sim_pc", new_pc, 32'h40);
    step(); at_neg();
    chk("sim_bl_flush", 32'(flush), 32'h0);
    chk("sim_bl_stall", 32'(stall), 32'h0);
    step(); exc = 32'h0; at_neg();
    chk("sim_stall2", 32'(stall), 32'h1f);
    step(); r_mem = 1'b0;

    // watchdog
    step();
    repeat (7) begin step(); r_ex = 1'b1; end
    step(); r_ex = 1'b0; at_neg();
    chk("wd_short", 32'(wdog_o), 32'h0);
    repeat (8) begin step(); r_ex = 1'b1; end
    step(); r_ex = 1'b0; at_neg();
    chk("wd_set", 32'(wdog_o), 32'h1);
    step(); at_neg();
    chk("wd_sticky", 32'(wdog_o), 32'h1);
    chk("stall_cnt21", stall_cnt_o, 32'd21);

    // reset in the middle of a flush cycle
    step(); exc = 32'h9; at_neg();
    chk("mid_flush", 32'(flush), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_flush", 32'(flush), 32'h0);
    chk("mid_rst_wd", 32'(wdog_o), 32'h0);
    step(); rst = 1'b0; exc = 32'ha; at_neg();
    chk("mid_run_flush", 32'(flush), 32'h1);
    chk("mid_run_pc", new_pc, 32'h40);
    step(); exc = 32'h0;
    step();

    // stall counter wrap
    step();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    m_sc = 32'hFFFF_FFFF;
    at_neg();
    release dut.stall_cnt;
    step(); r_if = 1'b1;
    step(); r_if = 1'b0; at_neg();
    chk("wrap", stall_cnt_o, 32'h0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
